// File: rtl/demux_pkg.sv
// Shared defaults and FSM state encoding for the serial demux/collector.
package demux_pkg;

    localparam int N_WAYS_DEF = 8;
    localparam int SEL_W_DEF  = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/demux_dec.sv
// Enable-gated select-to-one-hot decoder; produces the per-lane write strobe.
module demux_dec #(
    parameter int N_WAYS = 8,
    parameter int SEL_W  = 3
) (
    input  logic              i_en,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [N_WAYS-1:0] o_onehot
);

    for (genvar k = 0; k < N_WAYS; k++) begin : g_lane
        assign o_onehot[k] = i_en && (i_sel == SEL_W'(k));
    end

endmodule

// File: rtl/demux_collect.sv
// Steers serial bits into lanes by select code, then hands the finished word
// to a one-entry valid/ready output register.
module demux_collect
    import demux_pkg::*;
#(
    parameter int N_WAYS = N_WAYS_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d,
    input  logic [SEL_W-1:0]  s,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              flush,
    output logic [N_WAYS-1:0] y,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [N_WAYS-1:0] m,
    output logic              dup_err
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [N_WAYS-1:0] r_acc;
    logic [N_WAYS-1:0] r_m;
    logic [N_WAYS-1:0] r_y;
    logic              r_y_valid;
    logic              r_dup_err;

    logic              w_wr;
    logic [N_WAYS-1:0] w_lane;
    logic [N_WAYS-1:0] w_word;
    logic              w_complete;
    logic              w_slot_free;
    logic              w_load;
    logic [N_WAYS-1:0] w_load_word;

    assign d_ready = (r_state == COLLECT);

    // flush wins over a write in the same cycle, so the write strobe is masked.
    assign w_wr = d_valid && d_ready && !flush;

    demux_dec #(
        .N_WAYS (N_WAYS),
        .SEL_W  (SEL_W)
    ) u_dec (
        .i_en     (w_wr),
        .i_sel    (s),
        .o_onehot (w_lane)
    );

    assign w_word      = (r_acc & ~w_lane) | ({N_WAYS{d}} & w_lane);
    assign w_complete  = w_wr && (&(r_m | w_lane));
    assign w_slot_free = !r_y_valid || y_ready;
    assign w_load_word = (r_state == HOLD) ? r_acc : w_word;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_complete) begin
                    if (w_slot_free) w_load = 1'b1;
                    else             w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_state_nxt = COLLECT;
                end else if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= COLLECT;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_m       <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_dup_err <= 1'b0;
        end else begin
            r_dup_err <= w_wr && (|(r_m & w_lane));

            // Load and drain in the same cycle keeps y_valid high: no bubble.
            if (w_load) begin
                r_y       <= w_load_word;
                r_y_valid <= 1'b1;
            end else if (r_y_valid && y_ready) begin
                r_y_valid <= 1'b0;
            end

            if (flush || w_load) begin
                r_acc <= '0;
                r_m   <= '0;
            end else if (w_wr) begin
                // A completed word blocked by a full slot lands here and is
                // frozen in HOLD with an all-ones mask.
                r_acc <= w_word;
                r_m   <= r_m | w_lane;
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign m       = r_m;
    assign dup_err = r_dup_err;

endmodule

// File: tb/tb_demux_collect.sv
// Scoreboarded bench for demux_collect: words are queued as their last bit is
// driven and compared whenever the consumer takes y.
module tb_demux_collect;

    localparam int N  = 8;
    localparam int SW = 3;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          d       = 1'b0;
    logic [SW-1:0] s       = '0;
    logic          d_valid = 1'b0;
    logic          flush   = 1'b0;
    logic          y_ready = 1'b0;
    logic          d_ready;
    logic [N-1:0]  y;
    logic          y_valid;
    logic [N-1:0]  m;
    logic          dup_err;

    int           n_chk = 0;
    int           n_err = 0;
    logic [N-1:0] sb_q[$];

    always #5 clk = ~clk;

    demux_collect #(.N_WAYS(N), .SEL_W(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .s       (s),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .flush   (flush),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .m       (m),
        .dup_err (dup_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one bit for one cycle; every send in this bench targets COLLECT.
    task automatic send_bit(input logic [SW-1:0] sel, input logic b);
        chk("d_ready_on_send", 32'(d_ready), 32'd1);
        s       = sel;
        d       = b;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit rev);
        for (int i = 0; i < N; i++) begin
            int k;
            k = rev ? (N - 1 - i) : i;
            if (i == N - 1) sb_q.push_back(w);
            send_bit(SW'(k), w[k]);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Consumer side: a word is taken at the edge following a negedge that
    // sees y_valid && y_ready.
    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else                  chk("y_word", 32'(y), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] pat;

        // Reset state
        #2;
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_m", 32'(m), 32'd0);
        chk("rst_dup", 32'(dup_err), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd1);
        idle();
        idle();
        rst_n = 1'b1;
        idle();

        // In-order fill, y_valid exactly one cycle after the last bit
        y_ready = 1'b1;
        pat = 8'b0100_1101;
        for (int k = 0; k < N; k++) begin
            chk("fill_no_early_valid", 32'(y_valid), 32'd0);
            if (k == N - 1) sb_q.push_back(pat);
            send_bit(SW'(k), pat[k]);
        end
        chk("fill_valid", 32'(y_valid), 32'd1);
        chk("fill_y", 32'(y), 32'h4D);
        chk("fill_m_clear", 32'(m), 32'd0);
        idle();
        chk("fill_drained", 32'(y_valid), 32'd0);

        // Backpressure into HOLD
        y_ready = 1'b0;
        send_word(8'hA5, 1'b0);
        chk("bp_a_valid", 32'(y_valid), 32'd1);
        send_word(8'h3C, 1'b0);
        chk("bp_hold_rdy", 32'(d_ready), 32'd0);
        chk("bp_hold_m", 32'(m), 32'hFF);
        idle();
        chk("bp_hold_rdy2", 32'(d_ready), 32'd0);
        chk("bp_y_stable", 32'(y), 32'hA5);
        y_ready = 1'b1;
        idle();
        y_ready = 1'b0;
        chk("bp_b_y", 32'(y), 32'h3C);
        chk("bp_b_valid", 32'(y_valid), 32'd1);
        chk("bp_rdy_back", 32'(d_ready), 32'd1);
        chk("bp_m_clear", 32'(m), 32'd0);
        y_ready = 1'b1;
        idle();
        chk("bp_drained", 32'(y_valid), 32'd0);

        // Duplicate lane write
        send_bit(3'd3, 1'b1);
        chk("dup_first", 32'(dup_err), 32'd0);
        send_bit(3'd3, 1'b0);
        chk("dup_pulse", 32'(dup_err), 32'd1);
        chk("dup_m", 32'(m), 32'h08);
        send_bit(3'd0, 1'b1);
        chk("dup_once", 32'(dup_err), 32'd0);
        send_bit(3'd1, 1'b1);
        send_bit(3'd2, 1'b1);
        send_bit(3'd4, 1'b1);
        send_bit(3'd5, 1'b1);
        send_bit(3'd6, 1'b1);
        sb_q.push_back(8'hF7);
        send_bit(3'd7, 1'b1);
        chk("dup_y", 32'(y), 32'hF7);
        idle();

        // Flush with a colliding write, y held across it
        y_ready = 1'b0;
        send_word(8'h96, 1'b0);
        for (int k = 0; k < 6; k++) send_bit(SW'(k), 1'b1);
        chk("fl_m_pre", 32'(m), 32'h3F);
        s       = 3'd6;
        d       = 1'b1;
        d_valid = 1'b1;
        flush   = 1'b1;
        idle();
        d_valid = 1'b0;
        flush   = 1'b0;
        chk("fl_m", 32'(m), 32'd0);
        chk("fl_dup", 32'(dup_err), 32'd0);
        chk("fl_y_valid", 32'(y_valid), 32'd1);
        chk("fl_y", 32'(y), 32'h96);
        y_ready = 1'b1;
        send_word(8'h5A, 1'b1);
        chk("fl_new_y", 32'(y), 32'h5A);
        idle();

        // Simultaneous drain and load
        y_ready = 1'b0;
        send_word(8'hFF, 1'b0);
        for (int k = 0; k < N - 1; k++) send_bit(SW'(k), 1'b0);
        y_ready = 1'b1;
        sb_q.push_back(8'h00);
        send_bit(3'd7, 1'b0);
        chk("sim_valid", 32'(y_valid), 32'd1);
        chk("sim_y", 32'(y), 32'h00);
        idle();
        chk("sim_drained", 32'(y_valid), 32'd0);

        // Async reset while in HOLD
        y_ready = 1'b0;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        chk("ar_hold", 32'(d_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_y_valid", 32'(y_valid), 32'd0);
        chk("ar_m", 32'(m), 32'd0);
        chk("ar_y", 32'(y), 32'd0);
        chk("ar_d_ready", 32'(d_ready), 32'd1);
        sb_q.delete();
        #1;
        rst_n = 1'b1;
        idle();

        // Recovery after reset
        y_ready = 1'b1;
        send_word(8'hC3, 1'b0);
        chk("rec_y", 32'(y), 32'hC3);
        idle();
        idle();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
